// File: rtl/doodle_pkg.sv
// Shared types and playfield constants for the doodle physics block and its
// neighbours (control, renderer).
package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef logic [9:0]        pos_t;
  typedef logic signed [7:0] vel_t;

  localparam pos_t SCREEN_W      = 10'd640;
  localparam pos_t EARTH         = 10'd440;
  localparam pos_t DOODLE_HEIGHT = 10'd40;
  localparam pos_t DOODLE_WIDTH  = 10'd40;
  localparam pos_t X_START       = 10'd300;
  localparam pos_t Y_START       = EARTH - DOODLE_HEIGHT;

  localparam vel_t JUMP_VEL = 8'sd15;
  localparam vel_t GRAVITY  = 8'sd1;
  localparam vel_t MAX_FALL = 8'sd12;

  // Encoding 3 is not a legal phase; it behaves exactly like OVER.
  function automatic game_state_t decode_state(input logic [1:0] raw);
    game_state_t st;
    case (raw)
      2'd0:    st = IDLE;
      2'd1:    st = PLAY;
      default: st = OVER;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/doodle_axis_x.sv
// Combinational horizontal step: x + delta_x with screen-edge wrap, or wall
// saturation when DOODLE_WALL_CLAMP_EN is defined.
module doodle_axis_x
  import doodle_pkg::*;
(
  input  logic [9:0]        x,
  input  logic signed [8:0] delta_x,
  output logic [9:0]        x_next
);

  logic signed [11:0] x_sum;
  logic signed [11:0] x_fix;

  always_comb begin
    x_sum = $signed({2'b00, x}) + $signed({{3{delta_x[8]}}, delta_x});
`ifdef DOODLE_WALL_CLAMP_EN
    if (x_sum < 12'sd0) begin
      x_fix = 12'sd0;
    end else if (x_sum > $signed({2'b00, SCREEN_W - DOODLE_WIDTH})) begin
      x_fix = $signed({2'b00, SCREEN_W - DOODLE_WIDTH});
    end else begin
      x_fix = x_sum;
    end
`else
    // |delta_x| < SCREEN_W, so one correction always lands inside the screen.
    if (x_sum < 12'sd0) begin
      x_fix = x_sum + $signed({2'b00, SCREEN_W});
    end else if (x_sum >= $signed({2'b00, SCREEN_W})) begin
      x_fix = x_sum - $signed({2'b00, SCREEN_W});
    end else begin
      x_fix = x_sum;
    end
`endif
    x_next = pos_t'(x_fix);
  end

endmodule

// File: rtl/doodle_physics.sv
// Per-frame doodle integrator: gravity, platform bounce, ceiling/earth limits
// and horizontal wrap (wall clamp instead with DOODLE_WALL_CLAMP_EN).
module doodle_physics
  import doodle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic signed [8:0] delta_x,
  input  logic [1:0]        game_state,
  input  logic              platform_hit,
  output logic [9:0]        doodle_x,
  output logic [9:0]        doodle_y,
  output logic signed [7:0] vel_y,
  output logic              falling,
  output logic              jump_pulse
);

  game_state_t        phase;
  logic [9:0]         x_step;
  logic signed [11:0] y_sum;
  logic               bounce;
  vel_t               vel_grav;
  vel_t               vel_after;
  logic               launched;

  doodle_axis_x u_axis_x (
    .x       (doodle_x),
    .delta_x (delta_x),
    .x_next  (x_step)
  );

  always_comb begin
    phase  = decode_state(game_state);
    y_sum  = $signed({2'b00, doodle_y}) + $signed({{4{vel_y[7]}}, vel_y});
    // Only a descending doodle may bounce; hits on the way up are ignored.
    bounce = platform_hit && (vel_y > 8'sd0);
    if (vel_y >= MAX_FALL) begin
      vel_grav = MAX_FALL;
    end else begin
      vel_grav = vel_y + GRAVITY;
    end
    if (bounce) begin
      vel_after = -JUMP_VEL;
    end else begin
      vel_after = vel_grav;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doodle_x   <= X_START;
      doodle_y   <= Y_START;
      vel_y      <= 8'sd0;
      falling    <= 1'b0;
      jump_pulse <= 1'b0;
      launched   <= 1'b0;
    end else begin
      jump_pulse <= 1'b0;
      if (frame_tick) begin
        case (phase)
          IDLE: begin
            doodle_x <= X_START;
            doodle_y <= Y_START;
            vel_y    <= 8'sd0;
            falling  <= 1'b0;
            launched <= 1'b0;
          end
          PLAY: begin
            doodle_x <= x_step;
            if (!launched) begin
              vel_y      <= -JUMP_VEL;
              falling    <= 1'b0;
              launched   <= 1'b1;
              jump_pulse <= 1'b1;
            end else if (y_sum < 12'sd0) begin
              doodle_y <= 10'd0;
              vel_y    <= 8'sd0;
              falling  <= 1'b0;
            end else begin
              // Past the earth line the doodle parks at EARTH; control sees game over.
              if (y_sum > $signed({2'b00, EARTH})) begin
                doodle_y <= EARTH;
              end else begin
                doodle_y <= pos_t'(y_sum);
              end
              vel_y      <= vel_after;
              falling    <= (vel_after > 8'sd0);
              jump_pulse <= bounce;
            end
          end
          default: begin
            doodle_x <= doodle_x;
            doodle_y <= doodle_y;
            vel_y    <= vel_y;
            falling  <= falling;
            launched <= launched;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_doodle_physics.sv
// Scoreboard bench for doodle_physics: a plain-integer model predicts each
// frame's outputs; a monitor compares them the cycle after every frame_tick.
module tb_doodle_physics;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_tick;
  logic signed [8:0] delta_x;
  logic [1:0]        game_state;
  logic              platform_hit;
  logic [9:0]        doodle_x;
  logic [9:0]        doodle_y;
  logic signed [7:0] vel_y;
  logic              falling;
  logic              jump_pulse;

  doodle_physics dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .delta_x      (delta_x),
    .game_state   (game_state),
    .platform_hit (platform_hit),
    .doodle_x     (doodle_x),
    .doodle_y     (doodle_y),
    .vel_y        (vel_y),
    .falling      (falling),
    .jump_pulse   (jump_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int v;
    int p;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   mx, my, mv;
  bit   ml;
  bit   tick_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    mx = 300; my = 400; mv = 0; ml = 1'b0;
  endfunction

  // Frame rules written directly from the game description.
  function automatic int model_frame(input int gs, input int dx, input bit hit);
    int pulse = 0;
    int yn, xn;
    if (gs == 0) begin
      model_reset();
    end else if (gs == 1) begin
      xn = mx + dx;
`ifdef DOODLE_WALL_CLAMP_EN
      if (xn < 0) xn = 0;
      if (xn > 600) xn = 600;
`else
      if (xn < 0) xn += 640;
      else if (xn >= 640) xn -= 640;
`endif
      mx = xn;
      if (!ml) begin
        mv = -15; ml = 1'b1; pulse = 1;
      end else begin
        yn = my + mv;
        if (hit && mv > 0) begin
          mv = -15; pulse = 1;
        end else begin
          mv = (mv + 1 > 12) ? 12 : mv + 1;
        end
        if (yn < 0) begin
          my = 0; mv = 0;
        end else if (yn > 440) my = 440;
        else my = yn;
      end
    end
    return pulse;
  endfunction

  task automatic do_tick(input int gs, input int dx, input bit hit);
    exp_t e;
    @(posedge clk); #1;
    game_state   = 2'(gs);
    delta_x      = 9'(dx);
    platform_hit = hit;
    frame_tick   = 1'b1;
    e.p = model_frame(gs, dx, hit);
    e.x = mx; e.y = my; e.v = mv;
    q.push_back(e);
    @(posedge clk); #1;
    frame_tick   = 1'b0;
    platform_hit = 1'($urandom_range(0, 1));
    delta_x      = 9'($urandom_range(0, 511));
  endtask

  always @(posedge clk) tick_seen <= frame_tick;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (tick_seen) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = q.pop_front();
          chk("doodle_x", int'(doodle_x), e.x);
          chk("doodle_y", int'(doodle_y), e.y);
          chk("vel_y", int'(vel_y), e.v);
          chk("falling", int'(falling), (e.v > 0) ? 1 : 0);
          chk("jump_pulse", int'(jump_pulse), e.p);
        end
      end else begin
        chk("jump_pulse_clear", int'(jump_pulse), 0);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_x"}, int'(doodle_x), 300);
    chk({tag, "_y"}, int'(doodle_y), 400);
    chk({tag, "_vel"}, int'(vel_y), 0);
    chk({tag, "_pulse"}, int'(jump_pulse), 0);
    chk({tag, "_falling"}, int'(falling), 0);
  endtask

  initial begin
    int r, gs;
    rst = 1'b1; frame_tick = 1'b0; delta_x = '0; game_state = 2'd0; platform_hit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 3; i++) do_tick(0, $urandom_range(0, 40) - 20, 1'b0);
    // Launch, then steer x through both screen edges.
    do_tick(1, 0, 1'b0);
    do_tick(1, 0, 1'b0);
    do_tick(1, 255, 1'b0);
    do_tick(1, 80, 1'b1);
    do_tick(1, 5, 1'b0);
    do_tick(1, 2, 1'b0);
    do_tick(1, -5, 1'b0);
    // Bounce whenever descending; this climbs until the ceiling stops it.
    for (int i = 0; i < 90; i++)
      do_tick(1, $urandom_range(0, 60) - 30, (mv > 0) ? 1'b1 : 1'($urandom_range(0, 1)));

    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_state("reset_mid_play");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // No platforms: fall to the earth line, then freeze in OVER.
    for (int i = 0; i < 70; i++) do_tick(1, $urandom_range(0, 510) - 255, 1'b0);
    for (int i = 0; i < 4; i++) do_tick(2 + (i % 2), $urandom_range(0, 100) - 50, 1'($urandom_range(0, 1)));
    do_tick(0, 7, 1'b0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 39);
      gs = (r == 0) ? 0 : (r == 1) ? 2 : (r == 2) ? 3 : 1;
      do_tick(gs, $urandom_range(0, 510) - 255, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
